uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - UART transmitter, 8N1 framing by default: accepts one byte per valid/ready handshake, serialises it LSB-first onto tx_pin.
// - Sits between the design's byte producer and the board TX pin.
// - Peer of the UART receiver: uses the same baud arithmetic and the same idle-high line convention.
// PARAMETERS
// - clk_fre    50      Clock frequency in MHz (integer).
// - baud_rate  115200  Line rate in bit/s.
// - STOP_BITS  1       Stop bits per frame. Legal values: 1 or 2.
// - CYCLE (localparam) = clk_fre*1000000/baud_rate, integer divide. Clocks per bit.
//   - Required range: 2 <= CYCLE <= 65535; elaboration error otherwise.
// PORTS
// - clk            in   1  System clock. One clock domain only.
// - rst            in   1  Reset: asynchronous, active-high.
// - tx_data        in   8  Byte to send. Sampled on handshake.
// - tx_data_valid  in   1  Producer has a byte.
// - tx_data_ready  out  1  Block can accept a byte (high only in IDLE).
// - tx_busy        out  1  Frame in progress (high in any state other than IDLE).
// - tx_pin         out  1  Serial line. Registered output, idle high.
// BEHAVIOUR
// - Reset values (asynchronous, take effect immediately): tx_pin=1, tx_data_ready=1, tx_busy=0, state=IDLE, all counters=0, shift register=0.
// - Reset mid-frame: frame is abandoned, line returns high at once, no resume.
// - Handshake: transfer when tx_data_valid && tx_data_ready on a rising edge.
//   - tx_data is latched into the shift register at that edge.
//   - tx_data changes and valid toggles while busy are ignored.
// - State machine (3-bit encoding from the package):
//   - IDLE  -> START on handshake; tx_pin=0 from the next edge; ready drops at that same edge.
//   - START -> DATA after CYCLE clocks.
//   - DATA  -> sends bit_cnt=0..7, LSB first, each bit held exactly CYCLE clocks; after bit 7 -> PARITY if enabled, else STOP.
//   - PARITY (only with the macro) -> STOP after CYCLE clocks.
//   - STOP  -> tx_pin=1 for STOP_BITS*CYCLE clocks, then IDLE; ready=1 on the following cycle.
// - Timing:
//   - Handshake-to-start-bit latency: 1 clock.
//   - Frame length: (1+8+STOP_BITS)*CYCLE clocks, plus CYCLE with parity.
//   - Back-to-back: with valid held high, the next start bit begins exactly 1 clock after the stop period ends (one idle clock, line high).
// - Counters:
//   - cycle_cnt: 16-bit, counts 0..CYCLE-1, cleared on every state change and on each bit.
//   - bit_cnt: 3-bit, wraps 7->0 on the DATA->next transition.
//   - No wrap-around of cycle_cnt is possible inside the legal CYCLE range.
// - Illegal state: default branch -> IDLE, tx_pin=1.
// CONFIGURATION
// - Macro UART_TX_PARITY_EN: compiled in or out with the preprocessor.
//   - Defined: one even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bits; frame grows by CYCLE clocks.
//   - Undefined: no PARITY state and no parity logic; plain 8N1/8N2.
// STRUCTURE
// - Package uart_pkg, shared with the receiver:
//   - state encodings: IDLE, START, DATA, PARITY, STOP;
//   - function computing CYCLE from clk_fre/baud_rate;
//   - constants DATA_BITS=8 and CNT_W=16.
// - Sub-module uart_baud_cnt: CNT_W-bit bit-period counter.
//   - Inputs: clear, enable. Output: done when the count reaches CYCLE-1.
//   - Reusable by the receiver.
// - Top level holds the FSM, the shift register and the output register.
// TESTING (clk_fre=1, baud_rate=250000 -> CYCLE=4; check also the default 434)
// - Reset then idle: no valid for 100 clocks -> tx_pin=1, ready=1, busy=0 throughout.
// - Send 0x55: tx_pin low 1 clk after handshake, then 4-clk bits 1,0,1,0,1,0,1,0, then stop high 4 clks; ready returns at clk 41.
// - Back-to-back 0xA3 then 0x0F with valid held: two 40-clk frames separated by exactly 1 idle-high clk; loopback into the receiver returns 0xA3, 0x0F.
// - Input change while busy: present 0xFF, change tx_data to 0x00 mid-frame -> line carries 0xFF; the second byte is only accepted after ready returns.
// - Reset at clk 17 of a 0x81 frame: tx_pin=1 and busy=0 immediately; the next handshake produces a clean full frame.
// - UART_TX_PARITY_EN defined: 0x07 -> parity bit 1, 0x03 -> parity bit 0; frame is 44 clks (STOP_BITS=1).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   - uart_state_e : FSM state encoding (3 bits)
//   - calc_cycle   : clocks per bit from clock frequency (MHz) and baud rate
//   - DATA_BITS    : payload width
//   - CNT_W        : width of the bit-period counter
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Integer division truncates, so the line runs marginally fast when the
  // clock is not an exact multiple of the baud rate.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CYCLE-1 while enabled; done is high while the count sits at
// CYCLE-1. The user clears it on every bit boundary.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   clear  in  force the count to zero on the next edge (priority over enable)
//   enable in  advance the count by one
//   done   out count equals CYCLE-1
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CYCLE = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLE - 1);

  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (clear) begin
      cycle_cnt_d = '0;
    end else if (enable) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign done = (cycle_cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per valid/ready handshake and
// serialises it LSB-first as start bit, 8 data bits, optional even parity
// bit, then STOP_BITS stop bits. Line idles high.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bits.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   tx_data       in   byte to send, sampled on handshake
//   tx_data_valid in   producer has a byte
//   tx_data_ready out  high only in IDLE
//   tx_busy       out  high while a frame is in progress
//   tx_pin        out  registered serial line
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_fre   = 50,
  parameter int unsigned baud_rate = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int unsigned CYCLE     = calc_cycle(clk_fre, baud_rate);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  if ((CYCLE < 2) || (CYCLE > 65535)) begin : g_bad_cycle
    $error("uart_tx: clocks per bit out of range 2..65535");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 baud_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_cnt #(.CYCLE(CYCLE)) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .done   (baud_done)
  );

  // tx_pin_d always carries the value the line must show in the next state,
  // so the registered pin changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_pin_d  = tx_pin_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_en    = 1'b0;
        cnt_clear = 1'b1;
        bit_cnt_d = '0;
        tx_pin_d  = 1'b1;
        if (tx_data_valid) begin
          state_d  = START;
          shift_d  = tx_data;
          tx_pin_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (baud_done) begin
          cnt_clear = 1'b1;
          state_d   = DATA;
          tx_pin_d  = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_clear = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            tx_pin_d = parity_q;
`else
            state_d  = STOP;
            tx_pin_d = 1'b1;
`endif
          end else begin
            shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_pin_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          cnt_clear = 1'b1;
          state_d   = STOP;
          tx_pin_d  = 1'b1;
        end
      end
`endif
      STOP: begin
        // bit_cnt is reused here to count stop bits.
        if (baud_done) begin
          cnt_clear = 1'b1;
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        tx_pin_d  = 1'b1;
        bit_cnt_d = '0;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_pin_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_pin_q  <= tx_pin_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_data_ready = (state_q == IDLE);
  assign tx_busy       = (state_q != IDLE);
  assign tx_pin        = tx_pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a CYCLE=4 instance (clk_fre=1, baud_rate=250000) and a
// default-parameter instance (CYCLE=434). Expected line levels are queued
// clock by clock when a byte is handed over and compared every clock.
module tb_uart_tx;

  localparam int unsigned C_FAST    = 4;
  localparam int unsigned C_DEF     = 434;
  localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 10 + STOP_BITS;
`else
  localparam int unsigned FRAME_BITS = 9 + STOP_BITS;
`endif
  localparam int WAIT_MAX = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_f = '0, data_d = '0;
  logic       valid_f = 1'b0, valid_d = 1'b0;
  logic       ready_f, busy_f, pin_f;
  logic       ready_d, busy_d, pin_d;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic q_f[$];
  logic q_d[$];
  logic rdy_f = 1'b1;
  logic rdy_d = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    bit         b2b;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  uart_tx #(.clk_fre(1), .baud_rate(250000), .STOP_BITS(STOP_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (data_f),
    .tx_data_valid (valid_f),
    .tx_data_ready (ready_f),
    .tx_busy       (busy_f),
    .tx_pin        (pin_f)
  );

  uart_tx dut_def (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (data_d),
    .tx_data_valid (valid_d),
    .tx_data_ready (ready_d),
    .tx_busy       (busy_d),
    .tx_pin        (pin_d)
  );

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: {pin,busy,ready} got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample both DUTs on the falling edge against the queued levels.
  task automatic tick();
    logic b;
    @(negedge clk);
    cyc++;
    if (q_f.size() > 0) begin
      b = q_f.pop_front();
      rdy_f = 1'b0;
      check3("line_c4", {pin_f, busy_f, ready_f}, {b, 2'b10});
    end else begin
      rdy_f = 1'b1;
      check3("idle_c4", {pin_f, busy_f, ready_f}, 3'b101);
    end
    if (q_d.size() > 0) begin
      b = q_d.pop_front();
      rdy_d = 1'b0;
      check3("line_c434", {pin_d, busy_d, ready_d}, {b, 2'b10});
    end else begin
      rdy_d = 1'b1;
      check3("idle_c434", {pin_d, busy_d, ready_d}, 3'b101);
    end
  endtask

  task automatic push_level(input bit which, input logic lvl, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (which) q_d.push_back(lvl);
      else       q_f.push_back(lvl);
    end
  endtask

  task automatic push_frame(input bit which, input logic [7:0] d, input logic par);
    int unsigned c;
    c = which ? C_DEF : C_FAST;
    push_level(which, 1'b0, c);
    for (int b = 0; b < 8; b++) push_level(which, d[b], c);
`ifdef UART_TX_PARITY_EN
    push_level(which, par, c);
`else
    if (par === 1'bx) push_level(which, 1'bx, 0);
`endif
    push_level(which, 1'b1, STOP_BITS * c);
  endtask

  task automatic wait_ready(input bit which);
    int n;
    n = 0;
    while (!(which ? rdy_d : rdy_f)) begin
      tick();
      n++;
      if (n > WAIT_MAX) begin
        checks++;
        errors++;
        $display("FAIL wait_ready: no idle after %0d clocks, expected idle", n);
        return;
      end
    end
  endtask

  // Presents a byte on the falling edge before the accepting rising edge.
  task automatic send(input bit which, input logic [7:0] d, input logic par);
    wait_ready(which);
    if (which) begin
      data_d = d; valid_d = 1'b1;
    end else begin
      data_f = d; valid_f = 1'b1;
    end
    push_frame(which, d, par);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_f.size() > 0) || (q_d.size() > 0)) begin
      tick();
      n++;
      if (n > WAIT_MAX) begin
        checks++;
        errors++;
        $display("FAIL drain: queues not empty after %0d clocks, expected empty", n);
        return;
      end
    end
    tick();
  endtask

  initial begin
    int n;
    tbl[0] = '{8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 1'b1};
    tbl[2] = '{8'h0F, 1'b0, 1'b0};
    tbl[3] = '{8'h5B, 1'b1, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b0};
    tbl[5] = '{8'h03, 1'b0, 1'b1};
    tbl[6] = '{8'hC4, 1'b1, 1'b0};

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1 check3("reset_c4", {pin_f, busy_f, ready_f}, 3'b101);
    check3("reset_c434", {pin_d, busy_d, ready_d}, 3'b101);
    tick();
    rst = 1'b0;

    // Idle line for 100 clocks.
    repeat (100) tick();

    // 0x55: ready must return on clock FRAME_BITS*CYCLE+1 after the handshake.
    send(1'b0, 8'h55, 1'b0);
    tick();
    valid_f = 1'b0;
    n = 1;
    while ((ready_f !== 1'b1) && (n < 200)) begin
      tick();
      n++;
    end
    check_int("ready_return_0x55", n, int'(FRAME_BITS * C_FAST + 1));
    drain();

    // Table: b2b keeps valid high into the next entry.
    for (int i = 0; i < 7; i++) begin
      send(1'b0, tbl[i].data, tbl[i].parity);
      tick();
      if (!tbl[i].b2b) valid_f = 1'b0;
    end
    drain();

    // Input changes while busy are ignored; next byte waits for ready.
    send(1'b0, 8'hFF, 1'b0);
    repeat (10) tick();
    data_f  = 8'h00;
    valid_f = 1'b0;
    repeat (3) tick();
    valid_f = 1'b1;
    tick();
    send(1'b0, 8'h00, 1'b0);
    tick();
    valid_f = 1'b0;
    drain();

    // Reset 17 clocks into a 0x81 frame abandons it at once.
    send(1'b0, 8'h81, 1'b0);
    tick();
    valid_f = 1'b0;
    repeat (16) tick();
    check_int("pre_reset_busy", int'(busy_f), 1);
    #2 rst = 1'b1;
    #1 check3("midframe_reset", {pin_f, busy_f, ready_f}, 3'b101);
    q_f.delete();
    q_d.delete();
    repeat (2) tick();
    rst = 1'b0;
    send(1'b0, 8'h81, 1'b0);
    tick();
    valid_f = 1'b0;
    drain();

    // Default parameters: 434 clocks per bit.
    send(1'b1, 8'h3C, 1'b0);
    tick();
    valid_d = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
